// File: rtl/key_pkg.sv
// Shared definitions for the key conditioning blocks: FSM state encoding,
// default 50 MHz timing constants and a width helper for the shared counter.
package key_pkg;

    // Debounce / repeat FSM states, fixed 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        HELD      = 3'd2,
        REPEAT    = 3'd3,
        DEB_REL   = 3'd4
    } key_state_e;

    // Default timing at a 50 MHz board clock.
    localparam int DEF_DEBOUNCE_CYCLES = 32'sd1_000_000;   // 20 ms
    localparam int DEF_REPEAT_DELAY    = 32'sd25_000_000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 32'sd5_000_000;   // 100 ms
    localparam int DEF_REPEAT_EN       = 32'sd1;

    // Number of bits needed to hold values 0 .. v-1 (ceil(log2(v))).
    function automatic int clog2_w(input int v);
        int r;
        int x;
        r = 32'sd0;
        x = v - 32'sd1;
        while (x > 32'sd0) begin
            r = r + 32'sd1;
            x = x >>> 1;
        end
        return r;
    endfunction

    // Largest of three cycle counts; sizes the single shared counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Resets to 1, which is the "released" level of an active-low key or switch.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_pulse.sv
// Pushbutton conditioner: synchronizes an active-low key, debounces press and
// release, and produces single-cycle press/release pulses with optional
// hold-to-repeat. One shared counter times every state.
module key_pulse
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic level,
    output logic repeating
);

    localparam int CNT_W = clog2_w(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 32'sd1;

    // Terminal counts: every transition compares against limit-1.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 32'sd1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic             RPT_ON   = (REPEAT_EN != 32'sd0);

    logic             key_sync_s;
    logic             key_s;
    logic [CNT_W-1:0] cnt_inc_s;

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             level_q, level_d;
    logic             repeating_q, repeating_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (key_n),
        .q_o   (key_sync_s)
    );

    // Pressed is high-true from here on.
    assign key_s = ~key_sync_s;

    // Saturating increment so a long hold with repeat disabled never wraps.
    always_comb begin
        if (cnt_q == CNT_SAT) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CNT_W'(1);
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            level_q     <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            level_q     <= level_d;
            repeating_q <= repeating_d;
        end
    end

    // Next-state and output decode. A key change always wins over a
    // count expiry in the same cycle, so no pulse is issued then.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_inc_s;
        press_d     = 1'b0;
        release_d   = 1'b0;
        level_d     = level_q;
        repeating_d = repeating_q;

        case (state_q)
            IDLE: begin
                level_d     = 1'b0;
                repeating_d = 1'b0;
                cnt_d       = '0;
                if (key_s) begin
                    state_d = DEB_PRESS;
                end else begin
                    state_d = IDLE;
                end
            end

            DEB_PRESS: begin
                if (!key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end

            HELD: begin
                if (!key_s) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end else if (RPT_ON && (cnt_q == DLY_LAST)) begin
                    state_d     = REPEAT;
                    cnt_d       = '0;
                    press_d     = 1'b1;
                    repeating_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end

            REPEAT: begin
                if (!key_s) begin
                    state_d     = DEB_REL;
                    cnt_d       = '0;
                    repeating_d = 1'b0;
                end else if (cnt_q == PER_LAST) begin
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end

            DEB_REL: begin
                level_d = 1'b1;
                if (key_s) begin
                    // Bounce on release: back to held, repeat delay restarts.
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end

            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                level_d     = 1'b0;
                repeating_d = 1'b0;
            end
        endcase
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign level         = level_q;
    assign repeating     = repeating_q;

endmodule

// File: tb/tb_key_pulse.sv
// Bench for key_pulse: two instances (repeat on / repeat off) share one key
// and are compared every cycle against a run-length behavioural model,
// plus directed latency/timing measurements.
module tb_key_pulse;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic reset;
    logic key_n;

    logic press_r, release_r, level_r, repeating_r;
    logic press_n, release_n, level_n, repeating_n;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: recent key_n samples, debounced level, disagreement run
    // length, edges since the hold (re)started, previous seen key state.
    logic kq0, kq1, m_lvl, m_last_ks;
    int   m_run, m_age;
    logic e_press_r, e_press_n, e_rel, e_rep;

    key_pulse #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1)) dut_rep (
        .clk(clk), .reset(reset), .key_n(key_n),
        .press_pulse(press_r), .release_pulse(release_r), .level(level_r), .repeating(repeating_r)
    );

    key_pulse #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(0)) dut_norep (
        .clk(clk), .reset(reset), .key_n(key_n),
        .press_pulse(press_n), .release_pulse(release_n), .level(level_n), .repeating(repeating_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        kq0 = 1'b1; kq1 = 1'b1;
        m_lvl = 1'b0; m_last_ks = 1'b0;
        m_run = 0; m_age = 0;
        e_press_r = 1'b0; e_press_n = 1'b0; e_rel = 1'b0; e_rep = 1'b0;
    endtask

    // One clock edge of the reference: the key is seen two edges late; the
    // level flips once the seen key disagrees with it for D+1 edges in a row;
    // while held, pulses fire at hold age RD, RD+RP, RD+2RP, ...
    task automatic model_edge(input logic kn);
        logic ks;
        bit   pressed_now;
        ks  = ~kq1;
        kq1 = kq0;
        kq0 = kn;
        e_press_r = 1'b0; e_press_n = 1'b0; e_rel = 1'b0;
        pressed_now = 1'b0;
        if (ks != m_lvl) begin
            m_run++;
            if (m_run == D + 1) begin
                m_lvl = ks;
                m_run = 0;
                if (ks) begin
                    e_press_r = 1'b1; e_press_n = 1'b1;
                    m_age = 0; pressed_now = 1'b1;
                end else begin
                    e_rel = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
        if (m_lvl && ks && !pressed_now) begin
            if (!m_last_ks) m_age = 0;
            else            m_age++;
            if (m_age >= RD && ((m_age - RD) % RP) == 0) e_press_r = 1'b1;
        end
        e_rep = m_lvl && ks && (m_age >= RD);
        m_last_ks = ks;
    endtask

    task automatic check_outputs();
        chk("rep_press",     press_r,     e_press_r);
        chk("rep_release",   release_r,   e_rel);
        chk("rep_level",     level_r,     m_lvl);
        chk("rep_repeating", repeating_r, e_rep);
        chk("nr_press",      press_n,     e_press_n);
        chk("nr_release",    release_n,   e_rel);
        chk("nr_level",      level_n,     m_lvl);
        chk("nr_repeating",  repeating_n, 1'b0);
    endtask

    // Drive key_n at the falling edge, advance one clock, check at next fall.
    task automatic tick(input logic kn);
        key_n = kn;
        @(posedge clk);
        if (reset) model_edge(kn);
        else       model_reset();
        @(negedge clk);
        check_outputs();
    endtask

    // Pull reset low between clock edges; outputs must clear at once.
    task automatic async_reset();
        @(posedge clk);
        if (reset) model_edge(key_n);
        else       model_reset();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        tick(key_n);
        tick(key_n);
        reset = 1'b1;
    endtask

    initial begin
        int first;
        int cnt;
        int q[$];

        reset = 1'b0;
        key_n = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
        repeat (5) tick(1'b1);

        // 1: clean press, single pulse on the no-repeat instance.
        first = 0; cnt = 0;
        for (int e = 1; e <= 57; e++) begin
            tick(1'b0);
            if (press_n) begin cnt++; if (first == 0) first = e; end
        end
        chk("c1_press_edge", first, 7);
        chk("c1_press_count", cnt, 1);
        repeat (15) tick(1'b1);

        // 2: bounce burst rejected, then a single press.
        repeat (3) tick(1'b0);
        tick(1'b1);
        first = 0; cnt = 0;
        for (int e = 1; e <= 30; e++) begin
            tick(1'b0);
            if (press_n) begin cnt++; if (first == 0) first = e; end
        end
        chk("c2_press_edge", first, 7);
        chk("c2_press_count", cnt, 1);
        repeat (15) tick(1'b1);

        // 3: auto-repeat timing.
        for (int e = 1; e <= 47; e++) begin
            tick(1'b0);
            if (press_r) q.push_back(e);
        end
        chk("c3_pulse_count", q.size(), 12);
        if (q.size() >= 4) begin
            chk("c3_first_edge", q[0], 7);
            chk("c3_delay", q[1] - q[0], RD);
            chk("c3_period1", q[2] - q[1], RP);
            chk("c3_period2", q[3] - q[2], RP);
        end
        chk("c3_repeating", repeating_r, 1'b1);

        // 4: release latency, then a release glitch that must not release.
        first = 0;
        for (int e = 1; e <= 15; e++) begin
            tick(1'b1);
            if (release_r && first == 0) first = e;
        end
        chk("c4_release_edge", first, 7);
        chk("c4_level_after", level_r, 1'b0);
        repeat (12) tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        cnt = 0;
        for (int e = 1; e <= 20; e++) begin
            tick(1'b0);
            if (release_r || release_n) cnt++;
        end
        chk("c4_glitch_releases", cnt, 0);
        chk("c4_glitch_level", level_r, 1'b1);
        repeat (15) tick(1'b1);

        // 5: asynchronous reset during repeat, key kept low.
        repeat (25) tick(1'b0);
        chk("c5_in_repeat", repeating_r, 1'b1);
        async_reset();
        first = 0;
        for (int e = 1; e <= 20; e++) begin
            tick(1'b0);
            if (press_r && first == 0) first = e;
        end
        chk("c5_press_edge", first, 7);
        repeat (15) tick(1'b1);

        // 6: key drops in the cycle the repeat period expires.
        cnt = 0;
        for (int e = 1; e <= 17; e++) begin
            tick(1'b0);
            if (press_r) cnt++;
        end
        chk("c6_pulses_before", cnt, 2);
        cnt = 0;
        for (int e = 18; e <= 32; e++) begin
            tick(1'b1);
            if (press_r) cnt++;
        end
        chk("c6_pulses_after", cnt, 0);

        // Random runs of key levels with occasional resets.
        for (int k = 0; k < 40; k++) begin
            logic kn;
            int   len;
            kn  = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 18));
            for (int j = 0; j < len; j++) tick(kn);
            if ($urandom_range(0, 14) == 0) begin
                key_n = kn;
                async_reset();
            end
        end
        repeat (20) tick(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
